// File: rtl/ws281x_pkg.sv
// Shared types and timing helpers for the WS281x receive path.
package ws281x_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_e;

  localparam int unsigned PixelWidth        = 24;
  localparam int unsigned DefaultSysClkFreq = 25_000_000;
  localparam int unsigned DefaultT1ThreshNs = 600;
  localparam int unsigned DefaultMinHighNs  = 150;
  localparam int unsigned DefaultMaxHighNs  = 2000;
  localparam int unsigned DefaultLatchNs    = 50000;

  // clk_hz is a whole number of MHz, so dividing first keeps the product in range.
  function automatic int unsigned ns_to_cycles(input int unsigned clk_hz, input int unsigned ns);
    return ((clk_hz / 1_000_000) * ns) / 1000;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer primitive for bringing asynchronous levels into a clock domain.
module prim_flop_2sync #(
  parameter int unsigned    Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/ws281x_rx.sv
// WS281x NRZ receiver: measures high-pulse widths, assembles 24-bit pixels MSB-first,
// detects the latch gap and flags framing errors, delivering words over valid/ready.
module ws281x_rx
  import ws281x_pkg::*;
#(
  parameter int unsigned SysClkFreq = DefaultSysClkFreq,
  parameter int unsigned T1ThreshNs = DefaultT1ThreshNs,
  parameter int unsigned MinHighNs  = DefaultMinHighNs,
  parameter int unsigned MaxHighNs  = DefaultMaxHighNs,
  parameter int unsigned LatchNs    = DefaultLatchNs
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  ws281x_din_i,
  output logic [PixelWidth-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  frame_end_o,
  output logic                  err_o,
  output logic                  overrun_o,
  output logic                  idle_o
);

  localparam int unsigned ThreshCycles = ns_to_cycles(SysClkFreq, T1ThreshNs);
  localparam int unsigned MinCycles    = ns_to_cycles(SysClkFreq, MinHighNs);
  localparam int unsigned MaxCycles    = ns_to_cycles(SysClkFreq, MaxHighNs);
  localparam int unsigned LatchCycles  = ns_to_cycles(SysClkFreq, LatchNs);
  localparam int unsigned CntW         = $clog2(LatchCycles + 1);
  localparam int unsigned BitCntW      = $clog2(PixelWidth + 1);

  localparam logic [CntW-1:0]    CntMax  = '1;
  localparam logic [CntW-1:0]    ThreshC = CntW'(ThreshCycles);
  localparam logic [CntW-1:0]    MinC    = CntW'(MinCycles);
  localparam logic [CntW-1:0]    MaxC    = CntW'(MaxCycles);
  localparam logic [CntW-1:0]    LatchC  = CntW'(LatchCycles);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(PixelWidth - 1);

  logic din_sync;
  logic din_hist_q;
  logic rise;
  logic fall;

  prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b0)
  ) u_din_sync (
    .clk_i (clk_sys),
    .rst_ni(rst_sys_n),
    .d_i   (ws281x_din_i),
    .q_o   (din_sync)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      din_hist_q <= 1'b0;
    end else begin
      din_hist_q <= din_sync;
    end
  end

  assign rise = din_sync & ~din_hist_q;
  assign fall = ~din_sync & din_hist_q;

  logic [CntW-1:0] high_cnt_q;
  logic [CntW-1:0] low_cnt_q;

  // Both counters saturate so an arbitrarily long level never wraps back below a threshold.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
    end else begin
      if (rise) begin
        high_cnt_q <= CntW'(1);
      end else if (din_sync && high_cnt_q != CntMax) begin
        high_cnt_q <= high_cnt_q + 1'b1;
      end

      if (din_sync) begin
        low_cnt_q <= '0;
      end else if (fall) begin
        low_cnt_q <= CntW'(1);
      end else if (low_cnt_q != CntMax) begin
        low_cnt_q <= low_cnt_q + 1'b1;
      end
    end
  end

  rx_state_e              state_q, state_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PixelWidth-2:0]  shift_q, shift_d;
  logic                   err_q, err_d;
  logic                   frame_end_q, frame_end_d;
  logic                   bit_val;
  logic                   deliver;
  logic [PixelWidth-1:0]  pixel;

  assign bit_val = (high_cnt_q >= ThreshC);
  assign pixel   = {shift_q, bit_val};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    err_d       = 1'b0;
    frame_end_d = 1'b0;
    deliver     = 1'b0;

    unique case (state_q)
      SYNC: begin
        bit_cnt_d = '0;
        if (low_cnt_q >= LatchC) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (din_sync && high_cnt_q > MaxC) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = SYNC;
        end else if (fall) begin
          if (high_cnt_q < MinC) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = SYNC;
          end else begin
            shift_d = pixel[PixelWidth-2:0];
            if (bit_cnt_q == LastBit) begin
              deliver   = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (low_cnt_q >= LatchC) begin
          frame_end_d = 1'b1;
          if (bit_cnt_q != '0) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q     <= SYNC;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      frame_end_q <= frame_end_d;
    end
  end

  logic [PixelWidth-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // A held, unaccepted pixel wins over a new one so data_o never changes under the consumer.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && data_ready_i) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || data_ready_i) begin
        data_d  = pixel;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign err_o        = err_q;
  assign frame_end_o  = frame_end_q;
  assign idle_o       = (state_q == IDLE);

endmodule
